// File: rtl/blpix_pkg.sv
// Shared constants and types for the 10-pixel to 2-pixel line packer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package blpix_pkg;

  // Stored FIFO word: {sof, sol, din[79:0]}
  localparam int FW  = 82;
  // 16-bit output beats carved from each 80-bit input word
  localparam int BPW = 5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FPRE   = 3'd1,
    LINE   = 3'd2,
    LGAPST = 3'd3,
    LWAIT  = 3'd4
  } state_t;

  typedef struct packed {
    logic        sof;
    logic        sol;
    logic [79:0] din;
  } fword_t;

endpackage

// File: rtl/blfifo82.sv
// Synchronous FIFO of 82-bit words with a registered level.
// Latency: a pushed word is visible at head the cycle after the push.
// Backpressure: none; a push while full is ignored, a pop while empty is ignored.
module blfifo82
  import blpix_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   init_n,
  input  logic                   push,
  input  logic [FW-1:0]          wdata,
  input  logic                   pop,
  output logic [FW-1:0]          head,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [FW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Full/empty come from the registered level, so a same-cycle pop never frees room
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage array, written only on accepted pushes
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers and level
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/blpixpack.sv
// Buffers 80-bit pixel words and replays them as 16-bit beats framed by fval/lval.
// Latency: outputs trail the FSM state by one register stage.
// Backpressure: none; input is dropped when the FIFO is full (ovf), output underrun emits zeros (udr).
module blpixpack
  import blpix_pkg::*;
#(
  parameter int WPL       = 128,
  parameter int LINES     = 1024,
  parameter int DEPTH     = 16,
  parameter int START_LVL = 8,
  parameter int LGAP      = 4
) (
  input  logic        clk,
  input  logic        init_n,
  input  logic [79:0] din,
  input  logic        dval,
  input  logic        sol,
  input  logic        sof,
  output logic [15:0] dout,
  output logic        lval,
  output logic        fval,
  output logic        ovf,
  output logic        udr,
  output logic        serr
);

  localparam int LW  = $clog2(DEPTH) + 1;
  localparam int WCW = $clog2(WPL + 1);
  localparam int LCW = $clog2(LINES + 1);
  localparam int GCW = $clog2(LGAP + 2);

  state_t         state;
  state_t         nstate;
  logic [2:0]     sub_cnt;
  logic [WCW-1:0] word_cnt;
  logic [LCW-1:0] line_cnt;
  logic [GCW-1:0] gap_cnt;
  logic           slot_ok;

  logic [FW-1:0]  head_raw;
  fword_t         head_w;
  logic [LW-1:0]  level;
  logic           full;
  logic           empty;
  logic           fifo_pop;

  logic           beat_ok;
  logic           last_beat;
  logic           start_ok;
  logic           lvl_ok;
  logic           serr_set;
  logic           udr_set;
  logic [15:0]    pix_sel;
  logic [15:0]    beat_dat;

  blfifo82 #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .init_n (init_n),
    .push   (dval),
    .wdata  ({sof, sol, din}),
    .pop    (fifo_pop),
    .head   (head_raw),
    .level  (level),
    .full   (full),
    .empty  (empty)
  );

  assign head_w = head_raw;

  // Beat mux: lowest pixel pair first, highest pair on the fifth beat
  always_comb begin
    pix_sel = '0;
    case (sub_cnt)
      3'd0:    pix_sel = head_w.din[15:0];
      3'd1:    pix_sel = head_w.din[31:16];
      3'd2:    pix_sel = head_w.din[47:32];
      3'd3:    pix_sel = head_w.din[63:48];
      3'd4:    pix_sel = head_w.din[79:64];
      default: pix_sel = '0;
    endcase
  end

  // Next-state, FIFO pop and flag-set decode
  always_comb begin
    nstate    = state;
    fifo_pop  = 1'b0;
    serr_set  = 1'b0;
    udr_set   = 1'b0;
    beat_dat  = '0;
    // A word slot is judged once at its first beat; an empty FIFO there zeroes the whole slot
    beat_ok   = (sub_cnt == 3'd0) ? !empty : slot_ok;
    last_beat = (sub_cnt == 3'(BPW-1)) && (word_cnt == WCW'(WPL-1));
    lvl_ok    = (level >= LW'(START_LVL));
    start_ok  = lvl_ok && head_w.sol && !head_w.sof;
    case (state)
      IDLE: begin
        if (!empty) begin
          if (!head_w.sof) begin
            fifo_pop = 1'b1;
            serr_set = 1'b1;
          end else if (lvl_ok) begin
            nstate = FPRE;
          end
        end
      end
      FPRE: nstate = LINE;
      LINE: begin
        if (beat_ok) beat_dat = pix_sel;
        else         udr_set  = 1'b1;
        if (beat_ok && (sub_cnt == 3'(BPW-1))) fifo_pop = 1'b1;
        if (last_beat) begin
          if (line_cnt == LCW'(LINES-1)) nstate = IDLE;
          else if (LGAP == 0)            nstate = LWAIT;
          else                           nstate = LGAPST;
        end
      end
      LGAPST: begin
        // When the next line is already waiting, LWAIT is skipped so the gap is exactly LGAP
        if (gap_cnt == GCW'(LGAP-1)) nstate = start_ok ? LINE : LWAIT;
      end
      LWAIT: begin
        if (lvl_ok) begin
          if (start_ok) begin
            nstate = LINE;
          end else begin
            fifo_pop = 1'b1;
            serr_set = 1'b1;
          end
        end
      end
      default: nstate = IDLE;
    endcase
  end

  // State, beat/word/line/gap counters and sticky flags
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state    <= IDLE;
      sub_cnt  <= '0;
      word_cnt <= '0;
      line_cnt <= '0;
      gap_cnt  <= '0;
      slot_ok  <= 1'b0;
      ovf      <= 1'b0;
      udr      <= 1'b0;
      serr     <= 1'b0;
    end else begin
      state <= nstate;
      if (dval && full) ovf  <= 1'b1;
      if (udr_set)      udr  <= 1'b1;
      if (serr_set)     serr <= 1'b1;
      if (state == LINE) begin
        if (sub_cnt == 3'd0) slot_ok <= !empty;
        if (sub_cnt == 3'(BPW-1)) begin
          sub_cnt <= '0;
          if (word_cnt == WCW'(WPL-1)) begin
            word_cnt <= '0;
            line_cnt <= (nstate == IDLE) ? '0 : line_cnt + 1'b1;
          end else begin
            word_cnt <= word_cnt + 1'b1;
          end
        end else begin
          sub_cnt <= sub_cnt + 1'b1;
        end
      end
      gap_cnt <= (state == LGAPST) ? gap_cnt + 1'b1 : '0;
    end
  end

  // Registered video outputs; dout is zero whenever lval is low
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      dout <= '0;
      lval <= 1'b0;
      fval <= 1'b0;
    end else begin
      lval <= (state == LINE);
      fval <= (state != IDLE);
      dout <= (state == LINE) ? beat_dat : '0;
    end
  end

endmodule

// File: tb/tb_blpixpack.sv
// Self-checking bench for blpixpack with a beat-queue reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_blpixpack;

  localparam int WPL = 2, LINES = 2, DEPTH = 16, START_LVL = 1, LGAP = 4;
  localparam int BPL = WPL * 5;

  logic        clk = 1'b0;
  logic        init_n = 1'b1;
  logic [79:0] din = '0;
  logic        dval = 1'b0, sol = 1'b0, sof = 1'b0;
  logic [15:0] dout;
  logic        lval, fval, ovf, udr, serr;

  logic [79:0] din2 = '0;
  logic        dval2 = 1'b0, sol2 = 1'b0, sof2 = 1'b0;
  logic [15:0] dout2;
  logic        lval2, fval2, ovf2, udr2, serr2;

  blpixpack #(.WPL(WPL), .LINES(LINES), .DEPTH(DEPTH), .START_LVL(START_LVL), .LGAP(LGAP)) dut (
    .clk(clk), .init_n(init_n), .din(din), .dval(dval), .sol(sol), .sof(sof),
    .dout(dout), .lval(lval), .fval(fval), .ovf(ovf), .udr(udr), .serr(serr));

  blpixpack #(.WPL(16), .LINES(1), .DEPTH(16), .START_LVL(16), .LGAP(4)) dut_ovf (
    .clk(clk), .init_n(init_n), .din(din2), .dval(dval2), .sol(sol2), .sof(sof2),
    .dout(dout2), .lval(lval2), .fval(fval2), .ovf(ovf2), .udr(udr2), .serr(serr2));

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp2_q[$];
  logic [15:0] beat_log[1024];
  int          beat_idx = 0;
  int          frames_done = 0;
  bit          gap_exact = 1'b1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Model: every rendered word contributes five beats, pixel pair 0 first
  task automatic add_beats(input logic [79:0] w);
    for (int b = 0; b < 5; b++) exp_q.push_back(w[16*b +: 16]);
  endtask

  task automatic add_beats2(input logic [79:0] w);
    for (int b = 0; b < 5; b++) exp2_q.push_back(w[16*b +: 16]);
  endtask

  function automatic logic [79:0] mkpat(input int k);
    logic [79:0] w;
    for (int i = 0; i < 10; i++) w[8*i +: 8] = 8'(10*k + i);
    return w;
  endfunction

  function automatic logic [79:0] rnd_word();
    logic [79:0] w;
    w = {16'($urandom), $urandom, $urandom};
    return w;
  endfunction

  // Caller sits just after a rising edge; the word occupies one cycle
  task automatic send(input logic [79:0] d, input logic f, input logic l, input int gap_after);
    din = d; sof = f; sol = l | f; dval = 1'b1;
    @(posedge clk); #1;
    dval = 1'b0; sof = 1'b0; sol = 1'b0; din = '0;
    repeat (gap_after) begin @(posedge clk); #1; end
  endtask

  task automatic wait_frame(input string nm, input int budget);
    int tgt;
    int n;
    tgt = frames_done + 1;
    n = 0;
    while (frames_done < tgt && n < budget) begin @(negedge clk); n++; end
    check(nm, frames_done >= tgt, 1);
    check({nm, "_drained"}, exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // Compare process: framing rules and beat data against the model queue
  bit prev_l = 1'b0, prev_f = 1'b0;
  int run = 0, gap = 0, lines_in_frame = 0, pre = 0;
  always @(negedge clk) begin
    if (!init_n) begin
      prev_l = 1'b0; prev_f = 1'b0; run = 0; gap = 0; lines_in_frame = 0; pre = 0;
    end else begin
      if (!lval) check("dout_idle", dout, 0);
      if (lval) check("lval_in_fval", fval, 1);
      if (fval && !prev_f) pre = 0;
      if (lval) begin
        if (!prev_l) begin
          if (lines_in_frame == 0) check("fval_lead", pre, 1);
          else if (gap_exact)      check("line_gap", gap, LGAP);
          else                     check("line_gap_min", gap >= LGAP, 1);
          run = 0;
        end
        run++;
        check("beat_avail", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("beat_data", dout, exp_q.pop_front());
        if (beat_idx < 1024) beat_log[beat_idx] = dout;
        beat_idx++;
      end else begin
        if (prev_l) begin
          check("line_len", run, BPL);
          lines_in_frame++;
          if (lines_in_frame == LINES) begin
            check("fval_end", fval, 0);
            lines_in_frame = 0;
            frames_done++;
          end else begin
            check("fval_mid", fval, 1);
          end
          gap = 0;
        end
        if (fval && lines_in_frame == 0) pre++;
        if (fval) gap++;
      end
      prev_l = lval;
      prev_f = fval;
    end
  end

  initial begin
    #20000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n2;
    logic [79:0] w [4];
    logic [15:0] first2, last2;

    // Reset held with dval toggling: nothing may be stored or emitted
    #1 init_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      dval = ~dval; din = rnd_word(); sof = i[0]; sol = 1'b1;
      @(negedge clk);
      check("rst_out", {dout, lval, fval, ovf, udr, serr}, 0);
    end
    @(posedge clk); #1;
    dval = 1'b0; sof = 1'b0; sol = 1'b0; din = '0;
    init_n = 1'b1;
    repeat (20) begin @(posedge clk); #1; end
    check("rst_no_write", {fval, serr, ovf, udr}, 0);

    // Normal frame, words spaced five cycles apart
    base = beat_idx;
    for (int k = 0; k < 4; k++) add_beats(mkpat(k));
    send(mkpat(0), 1'b1, 1'b1, 4);
    send(mkpat(1), 1'b0, 1'b0, 4);
    send(mkpat(2), 1'b0, 1'b1, 4);
    send(mkpat(3), 1'b0, 1'b0, 0);
    wait_frame("normal_frame", 200);
    check("normal_beats", beat_idx - base, 20);
    check("normal_b0", beat_log[base], 16'h0100);
    check("normal_b5", beat_log[base + 5], 16'h0B0A);
    check("normal_b10", beat_log[base + 10], 16'h1514);
    check("normal_b19", beat_log[base + 19], 16'h2726);
    check("normal_flags", {ovf, udr, serr}, 0);

    // Randomized frames with random word spacing
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < 4; k++) begin w[k] = rnd_word(); add_beats(w[k]); end
      send(w[0], 1'b1, 1'b1, $urandom_range(0, 4));
      send(w[1], 1'b0, 1'b0, $urandom_range(0, 4));
      send(w[2], 1'b0, 1'b1, $urandom_range(0, 4));
      send(w[3], 1'b0, 1'b0, 0);
      wait_frame("rand_frame", 300);
      repeat ($urandom_range(0, 8)) begin @(posedge clk); #1; end
    end
    check("rand_flags", {ovf, udr, serr}, 0);

    // Sync error: a non-sof word in IDLE is discarded
    send(rnd_word(), 1'b0, 1'b0, 4);
    check("serr_set", serr, 1);
    check("serr_fval", fval, 0);
    for (int k = 0; k < 4; k++) begin w[k] = rnd_word(); add_beats(w[k]); end
    send(w[0], 1'b1, 1'b1, 1);
    send(w[1], 1'b0, 1'b0, 1);
    send(w[2], 1'b0, 1'b1, 1);
    send(w[3], 1'b0, 1'b0, 0);
    wait_frame("post_serr_frame", 200);
    check("serr_udr", udr, 0);

    // Underrun: second word of line 1 never arrives in time
    base = beat_idx;
    gap_exact = 1'b0;
    for (int k = 0; k < 3; k++) w[k] = rnd_word();
    add_beats(w[0]);
    for (int b = 0; b < 5; b++) exp_q.push_back(16'h0000);
    add_beats(w[1]);
    add_beats(w[2]);
    send(w[0], 1'b1, 1'b1, 29);
    send(w[1], 1'b0, 1'b1, 0);
    send(w[2], 1'b0, 1'b0, 0);
    wait_frame("udr_frame", 200);
    gap_exact = 1'b1;
    for (int b = 5; b < 10; b++) check("udr_zero_beat", beat_log[base + b], 16'h0000);
    check("udr_set", udr, 1);

    // Reset in the middle of line 1
    base = beat_idx;
    for (int k = 0; k < 4; k++) begin w[k] = rnd_word(); add_beats(w[k]); end
    send(w[0], 1'b1, 1'b1, 0);
    send(w[1], 1'b0, 1'b0, 0);
    send(w[2], 1'b0, 1'b1, 0);
    send(w[3], 1'b0, 1'b0, 0);
    for (int n = 0; n < 50 && (beat_idx - base) < 3; n++) begin @(negedge clk); #1; end
    check("midrst_at_beat3", beat_idx - base, 3);
    init_n = 1'b0;
    #1;
    check("midrst_async", {dout, lval, fval, ovf, udr, serr}, 0);
    exp_q.delete();
    repeat (2) begin @(posedge clk); #1; end
    init_n = 1'b1;
    @(posedge clk); #1;
    send(rnd_word(), 1'b0, 1'b0, 4);
    check("midrst_leftover_serr", serr, 1);
    check("midrst_leftover_fval", fval, 0);
    for (int k = 0; k < 4; k++) begin w[k] = rnd_word(); add_beats(w[k]); end
    send(w[0], 1'b1, 1'b1, 2);
    send(w[1], 1'b0, 1'b0, 2);
    send(w[2], 1'b0, 1'b1, 2);
    send(w[3], 1'b0, 1'b0, 0);
    wait_frame("midrst_clean_frame", 200);
    check("midrst_flags", {ovf, udr}, 0);

    // Overflow: 17 back-to-back words into a 16-deep FIFO
    for (int i = 0; i < 17; i++) begin
      din2 = mkpat(i); sof2 = (i == 0); sol2 = (i == 0); dval2 = 1'b1;
      if (i < 16) add_beats2(mkpat(i));
      if (i == 16) begin
        @(negedge clk);
        check("ovf_before_17th", ovf2, 0);
      end
      @(posedge clk); #1;
    end
    dval2 = 1'b0; sof2 = 1'b0; sol2 = 1'b0; din2 = '0;
    @(negedge clk);
    check("ovf_after_17th", ovf2, 1);
    n2 = 0; first2 = '0; last2 = '0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!lval2) begin
        if (dout2 !== 16'h0000) check("ovf_dout_idle", dout2, 0);
      end else begin
        check("ovf_beat_avail", exp2_q.size() > 0, 1);
        if (exp2_q.size() > 0) check("ovf_beat_data", dout2, exp2_q.pop_front());
        if (n2 == 0) first2 = dout2;
        last2 = dout2;
        n2++;
      end
    end
    check("ovf_beats", n2, 80);
    check("ovf_first", first2, 16'h0100);
    check("ovf_last", last2, 16'h9F9E);
    check("ovf_fval_done", fval2, 0);
    check("ovf_other_flags", {udr2, serr2}, 0);
    check("ovf_sticky", ovf2, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/blpixpack.md
BLPIXPACK -- requirements
Module: blpixpack

Interface
REQ-001 SHALL have parameter WPL, default 128, meaning 80-bit input words per line (1280 pixels).
REQ-002 SHALL have parameter LINES, default 1024, meaning lines per frame.
REQ-003 SHALL have parameter DEPTH, default 16, meaning FIFO depth in words (power of two).
REQ-004 SHALL have parameter START_LVL, default 8, meaning FIFO level required before a line is started (1..DEPTH).
REQ-005 SHALL have parameter LGAP, default 4, meaning minimum lval-low cycles between lines.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-007 SHALL have port init_n, input, 1; reset is asynchronous and active-low.
REQ-008 SHALL have port din, input, 80, ten 8-bit pixels, pixel0 in [7:0].
REQ-009 SHALL have port dval, input, 1, din valid strobe.
REQ-010 SHALL have port sol, input, 1, start of line, qualified by dval.
REQ-011 SHALL have port sof, input, 1, start of frame, qualified by dval, implies sol.
REQ-012 SHALL have port dout, output, 16, two pixels per beat, lower-index pixel in [7:0].
REQ-013 SHALL have port lval, output, 1, line valid.
REQ-014 SHALL have port fval, output, 1, frame valid.
REQ-015 SHALL have ports ovf, udr and serr, output, 1 each, sticky overflow, underrun and sync-error flags.

Function
REQ-016 SHALL store {sof,sol,din} in an 82-bit FIFO on each dval cycle when the registered level < DEPTH; when full, the word SHALL be dropped and ovf set, even if a pop occurs in the same cycle.
REQ-017 SHALL use states IDLE, FPRE, LINE, LGAPST and LWAIT.
REQ-018 In IDLE with a non-empty FIFO and head sof=0, SHALL pop the head word (one per cycle) and set serr.
REQ-019 In IDLE with head sof=1 and level >= START_LVL, SHALL go to FPRE; FPRE SHALL last exactly one cycle with fval=1 and lval=0.
REQ-020 LINE SHALL emit 5 beats per word, din[15:0] first and din[79:64] last, with lval=1, for exactly WPL*5 consecutive cycles; the head word SHALL be popped on its 5th beat.
REQ-021 If the FIFO is empty when a beat needs a word, the block SHALL emit dout=0 with lval held high, set udr, and consume the pending word slot without waiting.
REQ-022 After the line's last beat, the block SHALL go to LGAPST for LGAP cycles (lval=0, fval=1), then to LWAIT.
REQ-023 In LWAIT, when level >= START_LVL, SHALL enter LINE if head sol=1; if head sol=0 or sof=1 it SHALL pop the head and set serr.
REQ-024 After LINES lines, the last beat SHALL be followed by IDLE, with fval=0 from the next cycle; there SHALL be no LGAP.
REQ-025 dout, lval and fval SHALL be registered; dout SHALL be 0 whenever lval=0.
REQ-026 The line counter SHALL wrap to 0 on entry to IDLE, and the beat counter SHALL wrap to 0 at each line end.
REQ-027 ovf, udr and serr SHALL clear only on reset.

Reset
REQ-028 init_n low SHALL immediately clear dout, lval, fval, ovf, udr, serr, the FIFO pointers and level, and all counters, and SHALL force IDLE.
REQ-029 Reset asserted mid-line SHALL drop lval and fval asynchronously; after release, any partial-frame words written SHALL be handled by REQ-018.

Structure
REQ-030 State encodings, the FIFO word width (82) and the beats-per-word constant (5) SHALL reside in shared package blpix_pkg.
REQ-031 The FIFO SHALL be sub-module blfifo82 (synchronous, registered level, async active-low reset); the FSM and beat mux SHALL be in blpixpack.

Verification
Unless stated otherwise, tests use WPL=2, LINES=2, START_LVL=1, LGAP=4, DEPTH=16.
REQ-032 SHALL test reset: hold init_n=0 with dval toggling -> dout=0, lval=0, fval=0, all flags 0, no FIFO writes.
REQ-033 SHALL test a normal frame: 4 words (sof, -, sol, -) spaced 5 cycles apart, din=0x..0908..0100 pattern -> fval 1 cycle before lval; first beat 0x0100; 10 beats per line; lval low 4 cycles; fval low the cycle after the 20th beat; no flags.
REQ-034 SHALL test overflow: START_LVL=16, 17 back-to-back dval words, the first with sof -> 16 stored, the 17th dropped, ovf=1.
REQ-035 SHALL test underrun: a sof word, then the second word 30 cycles later -> beats 6-10 are 0x0000 with lval=1, udr=1, frame still completes.
REQ-036 SHALL test sync error: a word with sof=0 sent in IDLE -> popped next cycle, serr=1, fval stays 0.
REQ-037 SHALL test reset mid-operation: init_n low during beat 3 of line 1 -> lval=fval=0 immediately; a following clean frame is emitted correctly.
